pipe_stall_ctrl: RTL and testbench

- Pipeline-control sequencer that consumes hazard requests and drives the enable and bubble controls of the 5-stage 16-bit pipeline.
- Inputs are the load-use stall request, HLT decode in ID, taken branch from EX and the memory busy signal.
- Outputs are per-stage write enables, flush/bubble strobes, the halted flag and a stall-cycle performance counter.
- Owns HLT draining: once HLT reaches ID, older instructions drain, then the core halts permanently until reset.

---
 rtl/pipe_stall_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: hazard sequencer driving stage enables, flush/bubble strobes,
// HLT drain/halt and a saturating stall-cycle counter. Rev 1.0
`default_nettype none

module pipe_stall_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use,
  input  logic             hlt_id,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             pipe_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [3:0] c_DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_dcnt;
  logic [3:0]       w_dcnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_stall;

  // Outputs are gated by rst_n so every enable reads 0 while reset is held.
  always_comb begin
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    pipe_write   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    halted       = 1'b0;
    w_state_nxt  = r_state;
    w_dcnt_nxt   = r_dcnt;
    if (rst_n) begin
      case (r_state)
        RUN: begin
          if (!mem_busy) begin
            if (br_taken) begin
              pc_write     = 1'b1;
              if_id_write  = 1'b1;
              pipe_write   = 1'b1;
              if_id_flush  = 1'b1;
              id_ex_bubble = 1'b1;
            end else if (hlt_id) begin
              pipe_write   = 1'b1;
              id_ex_bubble = 1'b1;
              w_state_nxt  = DRAIN;
              w_dcnt_nxt   = c_DRAIN_LOAD;
            end else if (load_use) begin
              pipe_write   = 1'b1;
              id_ex_bubble = 1'b1;
            end else begin
              pc_write     = 1'b1;
              if_id_write  = 1'b1;
              pipe_write   = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (!mem_busy) begin
            if (br_taken) begin
              // The HLT being drained was on the wrong path: resume.
              pc_write     = 1'b1;
              if_id_write  = 1'b1;
              pipe_write   = 1'b1;
              if_id_flush  = 1'b1;
              id_ex_bubble = 1'b1;
              w_state_nxt  = RUN;
              w_dcnt_nxt   = 4'd0;
            end else begin
              pipe_write   = 1'b1;
              id_ex_bubble = 1'b1;
              if (r_dcnt == 4'd0) begin
                w_state_nxt = HALTED;
              end else begin
                w_dcnt_nxt = r_dcnt - 4'd1;
              end
            end
          end
        end
        HALTED: begin
          halted = 1'b1;
        end
        default: begin
          w_state_nxt = RUN;
          w_dcnt_nxt  = 4'd0;
        end
      endcase
    end
  end

  assign w_stall = !pc_write && (r_state != HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_dcnt      <= 4'd0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_dcnt  <= w_dcnt_nxt;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed and randomized checks of pipe_stall_ctrl against a
// behavioural model; instance b uses a 4-bit counter to reach saturation.
`default_nettype none

module tb_pipe_stall_ctrl;

  localparam int DC = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_use = 1'b0, hlt_id = 1'b0, br_taken = 1'b0, mem_busy = 1'b0;

  logic a_pc, a_ifid, a_pipe, a_flush, a_bubble, a_halted;
  logic b_pc, b_ifid, b_pipe, b_flush, b_bubble, b_halted;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  pipe_stall_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .load_use(load_use), .hlt_id(hlt_id),
    .br_taken(br_taken), .mem_busy(mem_busy), .pc_write(a_pc),
    .if_id_write(a_ifid), .pipe_write(a_pipe), .if_id_flush(a_flush),
    .id_ex_bubble(a_bubble), .halted(a_halted), .stall_cnt(a_cnt)
  );

  pipe_stall_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .load_use(load_use), .hlt_id(hlt_id),
    .br_taken(br_taken), .mem_busy(mem_busy), .pc_write(b_pc),
    .if_id_write(b_ifid), .pipe_write(b_pipe), .if_id_flush(b_flush),
    .id_ex_bubble(b_bubble), .halted(b_halted), .stall_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Model: mode 0 = running, 1 = draining, 2 = halted; left = drain cycles still owed after this one.
  int m_mode, m_left, m_cnt;
  logic [5:0] exp_ctrl, obs_a, obs_b;
  int exp_cnt;
  logic [15:0] obs_cnt_a;
  logic [3:0]  obs_cnt_b;

  // ctrl vector order: {pc_write, if_id_write, pipe_write, if_id_flush, id_ex_bubble, halted}
  localparam logic [5:0] K_NORMAL = 6'b111000;
  localparam logic [5:0] K_FLUSH  = 6'b111110;
  localparam logic [5:0] K_BUBBLE = 6'b001010;
  localparam logic [5:0] K_FREEZE = 6'b000000;
  localparam logic [5:0] K_HALT   = 6'b000001;

  function automatic int sat4(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_left = 0; m_cnt = 0;
  endtask

  // Called at a negedge; applies inputs, samples both DUTs before the edge, advances the model.
  task automatic cycle(input logic lu, input logic hlt, input logic br, input logic mb);
    load_use = lu; hlt_id = hlt; br_taken = br; mem_busy = mb;
    #2;
    exp_cnt = m_cnt;
    if (m_mode == 2)                        exp_ctrl = K_HALT;
    else if (mb)                            exp_ctrl = K_FREEZE;
    else if (br)                            exp_ctrl = K_FLUSH;
    else if (m_mode == 1 || hlt || lu)      exp_ctrl = K_BUBBLE;
    else                                    exp_ctrl = K_NORMAL;
    obs_a = {a_pc, a_ifid, a_pipe, a_flush, a_bubble, a_halted};
    obs_b = {b_pc, b_ifid, b_pipe, b_flush, b_bubble, b_halted};
    obs_cnt_a = a_cnt;
    obs_cnt_b = b_cnt;
    if (m_mode != 2) begin
      if (mb) m_cnt++;
      else if (br) m_mode = 0;
      else if (m_mode == 1) begin
        m_cnt++;
        if (m_left == 0) m_mode = 2; else m_left--;
      end else if (hlt) begin
        m_cnt++; m_mode = 1; m_left = DC - 1;
      end else if (lu) m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    load_use = 1'b1; hlt_id = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;
    model_reset();
    @(negedge clk);
    total++;
    if ({a_pc, a_ifid, a_pipe, a_flush, a_bubble, a_halted} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl_a got=%b want=%b", {a_pc, a_ifid, a_pipe, a_flush, a_bubble, a_halted}, 6'b0);
    end
    total++;
    if ({b_pc, b_ifid, b_pipe, b_flush, b_bubble, b_halted} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl_b got=%b want=%b", {b_pc, b_ifid, b_pipe, b_flush, b_bubble, b_halted}, 6'b0);
    end
    total++;
    if (a_cnt !== 16'd0 || b_cnt !== 4'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", a_cnt, b_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    do_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_a !== K_BUBBLE) begin
      bad++; $display("FAIL load_use_ctrl got=%b want=%b", obs_a, K_BUBBLE);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_a !== K_NORMAL) begin
      bad++; $display("FAIL load_use_after got=%b want=%b", obs_a, K_NORMAL);
    end
    total++;
    if (obs_cnt_a !== 16'd1) begin
      bad++; $display("FAIL load_use_cnt got=%0d want=1", obs_cnt_a);
    end
  endtask

  task automatic test_branch_vs_load_use();
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    total++;
    if (obs_a !== K_FLUSH) begin
      bad++; $display("FAIL branch_ctrl got=%b want=%b", obs_a, K_FLUSH);
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_cnt_a !== 16'd1) begin
      bad++; $display("FAIL branch_cnt got=%0d want=1", obs_cnt_a);
    end
  endtask

  task automatic test_hlt_drain();
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (obs_a !== K_BUBBLE) begin
      bad++; $display("FAIL hlt_accept got=%b want=%b", obs_a, K_BUBBLE);
    end
    for (int i = 1; i <= DC; i++) begin
      cycle(1'($urandom), 1'($urandom), 1'b0, 1'b0);
      total++;
      if (obs_a !== K_BUBBLE) begin
        bad++; $display("FAIL hlt_drain_c%0d got=%b want=%b", i, obs_a, K_BUBBLE);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      total++;
      if (obs_a !== K_HALT || obs_cnt_a !== 16'd4) begin
        bad++; $display("FAIL hlt_halted_c%0d got=%b/%0d want=%b/4", i, obs_a, obs_cnt_a, K_HALT);
      end
    end
  endtask

  task automatic test_wrong_path_hlt();
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (obs_a !== K_FLUSH) begin
      bad++; $display("FAIL wrongpath_flush got=%b want=%b", obs_a, K_FLUSH);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (obs_a !== K_NORMAL) begin
        bad++; $display("FAIL wrongpath_run_c%0d got=%b want=%b", i, obs_a, K_NORMAL);
      end
    end
    total++;
    if (obs_cnt_a !== 16'd2) begin
      bad++; $display("FAIL wrongpath_cnt got=%0d want=2", obs_cnt_a);
    end
  endtask

  task automatic test_mem_freeze();
    logic [5:0] seq [7];
    seq = '{K_BUBBLE, K_BUBBLE, K_FREEZE, K_FREEZE, K_BUBBLE, K_BUBBLE, K_HALT};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, i == 0, 1'b0, i == 2 || i == 3);
      total++;
      if (obs_a !== seq[i]) begin
        bad++; $display("FAIL freeze_c%0d got=%b want=%b", i, obs_a, seq[i]);
      end
    end
    total++;
    if (obs_cnt_a !== 16'd6) begin
      bad++; $display("FAIL freeze_cnt got=%0d want=6", obs_cnt_a);
    end
  endtask

  task automatic test_saturation_and_async_reset();
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (b_cnt !== 4'd15 || a_cnt !== 16'd20) begin
      bad++; $display("FAIL saturate got=%0d/%0d want=15/20", b_cnt, a_cnt);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DC + 1; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs_b !== K_HALT || obs_cnt_b !== 4'd15) begin
      bad++; $display("FAIL sat_halted got=%b/%0d want=%b/15", obs_b, obs_cnt_b, K_HALT);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (a_halted !== 1'b0 || b_halted !== 1'b0 || a_cnt !== 16'd0 || b_cnt !== 4'd0) begin
      bad++; $display("FAIL async_reset got=%b%b/%0d/%0d want=00/0/0", a_halted, b_halted, a_cnt, b_cnt);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      if (n % 120 == 0) do_reset();
      cycle($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 20);
      total++;
      if (obs_a !== exp_ctrl || obs_b !== exp_ctrl) begin
        bad++; $display("FAIL rand_ctrl n=%0d got=%b/%b want=%b", n, obs_a, obs_b, exp_ctrl);
      end
      total++;
      if (obs_cnt_a !== 16'(exp_cnt) || obs_cnt_b !== 4'(sat4(exp_cnt))) begin
        bad++; $display("FAIL rand_cnt n=%0d got=%0d/%0d want=%0d/%0d", n, obs_cnt_a, obs_cnt_b, exp_cnt, sat4(exp_cnt));
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_vs_load_use();
    test_hlt_drain();
    test_wrong_path_hlt();
    test_mem_freeze();
    test_saturation_and_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
